// File: rtl/pixie_video_scanout.sv
// Pixie frame-buffer scan-out: raster timing generator plus byte fetch and
// MSB-first serialiser, with every stored row replayed ROW_REPEAT times.
module pixie_video_scanout #(
  parameter int BYTES_PER_ROW = 8,
  parameter int ROWS          = 32,
  parameter int ROW_REPEAT    = 4,
  parameter int H_TOTAL       = 112,
  parameter int H_SYNC_LEN    = 12,
  parameter int H_ACT_START   = 32,
  parameter int V_TOTAL       = 262,
  parameter int V_SYNC_LEN    = 4,
  parameter int V_ACT_START   = 80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       disp_on,
  output logic       fb_en,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       pixel,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start
);
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW        = (ROW_REPEAT > 1) ? $clog2(ROW_REPEAT) : 1;
  localparam int ACT_LINES = ROWS * ROW_REPEAT;
  localparam int ACT_SLOTS = 8 * BYTES_PER_ROW;

  typedef enum logic [1:0] {
    ST_VSYNC      = 2'd0,
    ST_VBLANK_TOP = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_VBLANK_BOT = 2'd3
  } vstate_t;

  vstate_t       vstate_r;
  logic [HW-1:0] hcount_r;
  logic [VW-1:0] vcount_r;
  logic [RW-1:0] row_r;
  logic [PW-1:0] rep_r;
  logic [7:0]    next_byte_r;
  logic [7:0]    shift_r;
  logic          fb_en_d_r;
  logic          disp_latched_r;

  logic          h_last_s;
  logic          v_last_s;
  logic [VW-1:0] vcount_next_s;
  logic [HW-1:0] fetch_off_s;
  logic          in_fetch_s;
  logic          in_act_h_s;
  logic          line_act_s;
  logic [7:0]    src_s;

  // Slot decode for the position currently being processed
  always_comb begin
    h_last_s    = (hcount_r == HW'(H_TOTAL - 1));
    v_last_s    = (vcount_r == VW'(V_TOTAL - 1));
    fetch_off_s = hcount_r - HW'(H_ACT_START - 1);
    in_fetch_s  = (int'(hcount_r) >= H_ACT_START - 1) &&
                  (int'(hcount_r) <  H_ACT_START - 1 + ACT_SLOTS) &&
                  (fetch_off_s[2:0] == 3'd0);
    in_act_h_s  = (int'(hcount_r) >= H_ACT_START) &&
                  (int'(hcount_r) <  H_ACT_START + ACT_SLOTS);
    line_act_s  = (vstate_r == ST_ACTIVE);
    if (v_last_s) begin
      vcount_next_s = '0;
    end else begin
      vcount_next_s = vcount_r + VW'(1);
    end
    // Byte boundary: take a byte that landed this very clk straight off the bus
    if ((hcount_r[2:0] - 3'(H_ACT_START)) == 3'd0) begin
      if (fb_en_d_r) begin
        src_s = fb_data;
      end else begin
        src_s = next_byte_r;
      end
    end else begin
      src_s = shift_r;
    end
  end

  // Raster counters, vertical FSM, fetch and serialiser state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vstate_r       <= ST_VSYNC;
      hcount_r       <= '0;
      vcount_r       <= '0;
      row_r          <= '0;
      rep_r          <= '0;
      next_byte_r    <= 8'd0;
      shift_r        <= 8'd0;
      fb_en_d_r      <= 1'b0;
      disp_latched_r <= 1'b0;
      fb_en          <= 1'b0;
      fb_addr        <= 10'd0;
      pixel          <= 1'b0;
      hsync_n        <= 1'b1;
      vsync_n        <= 1'b1;
      hblank         <= 1'b1;
      vblank         <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      fb_en       <= 1'b0;
      frame_start <= 1'b0;
      fb_en_d_r   <= fb_en;
      if (fb_en_d_r) begin
        next_byte_r <= fb_data;
      end
      if (ce_pix) begin
        hsync_n <= !(int'(hcount_r) < H_SYNC_LEN);
        vsync_n <= !(int'(vcount_r) < V_SYNC_LEN);
        hblank  <= !in_act_h_s;
        vblank  <= !line_act_s;
        if (hcount_r == HW'(0) && vcount_r == VW'(0)) begin
          frame_start    <= 1'b1;
          disp_latched_r <= disp_on;
        end
        if (line_act_s && disp_latched_r && in_fetch_s) begin
          fb_en   <= 1'b1;
          fb_addr <= 10'(row_r) * 10'(BYTES_PER_ROW) + 10'(fetch_off_s[HW-1:3]);
        end
        if (line_act_s && in_act_h_s) begin
          pixel   <= src_s[7] & disp_latched_r;
          shift_r <= {src_s[6:0], 1'b0};
        end else begin
          pixel   <= 1'b0;
        end
        if (h_last_s) begin
          hcount_r <= '0;
          vcount_r <= vcount_next_s;
          case (vstate_r)
            ST_VSYNC: begin
              if (vcount_next_s == VW'(V_SYNC_LEN)) vstate_r <= ST_VBLANK_TOP;
            end
            ST_VBLANK_TOP: begin
              if (vcount_next_s == VW'(V_ACT_START)) begin
                vstate_r <= ST_ACTIVE;
                row_r    <= '0;
                rep_r    <= '0;
              end
            end
            ST_ACTIVE: begin
              if (v_last_s) begin
                vstate_r <= ST_VSYNC;
              end else if (vcount_next_s == VW'(V_ACT_START + ACT_LINES)) begin
                vstate_r <= ST_VBLANK_BOT;
              end else if (rep_r == PW'(ROW_REPEAT - 1)) begin
                rep_r <= '0;
                // Saturate so the address never walks into unused buffer space
                if (row_r != RW'(ROWS - 1)) row_r <= row_r + RW'(1);
              end else begin
                rep_r <= rep_r + PW'(1);
              end
            end
            ST_VBLANK_BOT: begin
              if (v_last_s) vstate_r <= ST_VSYNC;
            end
            default: vstate_r <= ST_VSYNC;
          endcase
        end else begin
          hcount_r <= hcount_r + HW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pixie_video_scanout.sv
// Self-checking bench for pixie_video_scanout: slot-accurate reference model
// feeding a scoreboard, plus a table of hand-computed probe points.
module tb_pixie_video_scanout;
  // Reduced vertical geometry keeps several frames within the cycle budget
  localparam int BPR = 8, NROWS = 8, RREP = 4;
  localparam int HT = 112, HS = 12, HA = 32;
  localparam int VT = 60, VS = 4, VA = 20;
  localparam int NP = 14;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix = 1'b0;
  logic       disp_on = 1'b0;
  logic       fb_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       pixel, hsync_n, vsync_n, hblank, vblank, frame_start;

  always #5 clk = ~clk;

  pixie_video_scanout #(
    .BYTES_PER_ROW(BPR), .ROWS(NROWS), .ROW_REPEAT(RREP),
    .H_TOTAL(HT), .H_SYNC_LEN(HS), .H_ACT_START(HA),
    .V_TOTAL(VT), .V_SYNC_LEN(VS), .V_ACT_START(VA)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .disp_on(disp_on),
    .fb_en(fb_en), .fb_addr(fb_addr), .fb_data(fb_data), .pixel(pixel),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .hblank(hblank), .vblank(vblank),
    .frame_start(frame_start)
  );

  logic [7:0] mem [0:1023];

  // Frame buffer with registered read
  always_ff @(posedge clk) begin
    if (fb_en) fb_data <= mem[fb_addr];
  end

  typedef struct packed {
    logic       fb_en;
    logic [9:0] fb_addr;
    logic       pixel, hsync_n, vsync_n, hblank, vblank, frame_start;
  } exp_t;

  typedef struct {
    int line, slot, fb_en, fb_addr, pixel, hblank, vblank, frame_start;
  } probe_t;

  probe_t     probes [NP];
  exp_t       sb_q [$];
  exp_t       got;
  int         checks = 0, errors = 0, fs_cnt = 0;
  int         mh = 0, mv = 0, ph = 0, pv = 0;
  bit         mdisp = 1'b0;
  logic [9:0] mlast = 10'd0;

  task automatic chk(input string name, input int actual, input int want);
    checks++;
    if (actual != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (line %0d slot %0d)", name, actual, want, pv, ph);
    end
  endtask

  task automatic chk_reset();
    chk("rst_fb_en", fb_en, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_frame_start", frame_start, 0);
  endtask

  // Reference model: expected outputs for the slot at (mh, mv)
  task automatic model_slot(output exp_t e);
    int row;
    logic act_v, act_h;
    logic [7:0] b;
    act_v = (mv >= VA) && (mv < VA + NROWS * RREP);
    act_h = (mh >= HA) && (mh < HA + 8 * BPR);
    row = act_v ? (mv - VA) / RREP : 0;
    e.frame_start = (mh == 0) && (mv == 0);
    if (e.frame_start) mdisp = disp_on;
    e.hsync_n = !(mh < HS);
    e.vsync_n = !(mv < VS);
    e.hblank  = !act_h;
    e.vblank  = !act_v;
    e.fb_en   = act_v && mdisp && (mh >= HA - 1) && (mh < HA - 1 + 8 * BPR) &&
                ((mh - (HA - 1)) % 8 == 0);
    if (e.fb_en) mlast = 10'(row * BPR + (mh - (HA - 1)) / 8);
    e.fb_addr = mlast;
    if (act_v && act_h && mdisp) begin
      b = mem[row * BPR + (mh - HA) / 8];
      e.pixel = b[7 - ((mh - HA) % 8)];
    end else begin
      e.pixel = 1'b0;
    end
  endtask

  task automatic do_slot(input int gap, output exp_t g);
    exp_t e, w;
    model_slot(e);
    sb_q.push_back(e);
    ph = mh;
    pv = mv;
    @(negedge clk) ce_pix = 1'b1;
    @(posedge clk) #1 ce_pix = 1'b0;
    g = {fb_en, fb_addr, pixel, hsync_n, vsync_n, hblank, vblank, frame_start};
    w = sb_q.pop_front();
    chk("fb_en", g.fb_en, w.fb_en);
    chk("fb_addr", g.fb_addr, w.fb_addr);
    chk("pixel", g.pixel, w.pixel);
    chk("hsync_n", g.hsync_n, w.hsync_n);
    chk("vsync_n", g.vsync_n, w.vsync_n);
    chk("hblank", g.hblank, w.hblank);
    chk("vblank", g.vblank, w.vblank);
    chk("frame_start", g.frame_start, w.frame_start);
    if (g.frame_start) fs_cnt++;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk) #1;
      chk("fb_en_width", fb_en, 0);
      chk("frame_start_width", frame_start, 0);
      chk("pixel_hold", pixel, w.pixel);
      chk("fb_addr_hold", fb_addr, w.fb_addr);
    end
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic set_probe(input int i, input int l, input int s, input int en, input int a,
                           input int p, input int hb, input int vb, input int fs);
    probes[i] = '{l, s, en, a, p, hb, vb, fs};
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    mem[0] = 8'h81;
    //         line slot en addr pix hb vb fs
    set_probe(0,   0,   0, 0,  0,  0, 1, 1, 1);
    set_probe(1,  20,  31, 1,  0,  0, 1, 0, 0);
    set_probe(2,  20,  32, 0,  0,  1, 0, 0, 0);
    set_probe(3,  20,  33, 0,  0,  0, 0, 0, 0);
    set_probe(4,  20,  38, 0,  0,  0, 0, 0, 0);
    set_probe(5,  20,  39, 1,  1,  1, 0, 0, 0);
    set_probe(6,  20,  47, 1,  2,  1, 0, 0, 0);
    set_probe(7,  23,  31, 1,  0,  0, 1, 0, 0);
    set_probe(8,  24,  31, 1,  8,  0, 1, 0, 0);
    set_probe(9,  24,  36, 0,  8,  1, 0, 0, 0);
    set_probe(10, 51,  87, 1, 63,  0, 0, 0, 0);
    set_probe(11, 51,  95, 0, 63,  1, 0, 0, 0);
    set_probe(12, 51,  96, 0, 63,  0, 1, 0, 0);
    set_probe(13, 52,  31, 0, 63,  0, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) reset_n = 1'b1;

    // Frame 1: display latched off; raising disp_on mid-frame must not take effect
    for (int s = 0; s < HT * VT; s++) begin
      if (mv == 30 && mh == 0) disp_on = 1'b1;
      do_slot(2, got);
    end
    chk("frame_start_per_frame", fs_cnt, 1);

    // Frame 2: display on, hand-computed probe points
    for (int p = 0; p < NP; p++) begin
      while (!(mv == probes[p].line && mh == probes[p].slot)) do_slot(2, got);
      do_slot(2, got);
      chk("probe_fb_en", got.fb_en, probes[p].fb_en);
      chk("probe_fb_addr", got.fb_addr, probes[p].fb_addr);
      chk("probe_pixel", got.pixel, probes[p].pixel);
      chk("probe_hblank", got.hblank, probes[p].hblank);
      chk("probe_vblank", got.vblank, probes[p].vblank);
      chk("probe_frame_start", got.frame_start, probes[p].frame_start);
    end
    while (!(mh == 0 && mv == 0)) do_slot(2, got);
    chk("frame_start_two_frames", fs_cnt, 2);

    // Frame 3 with irregular ce_pix, interrupted by a reset mid-line
    while (!(mv == 30 && mh == 50)) do_slot($urandom_range(2, 4), got);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset();
    mh = 0;
    mv = 0;
    mdisp = 1'b0;
    mlast = 10'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    do_slot(3, got);
    chk("frame_start_after_reset", got.frame_start, 1);
    while (mv != VA + NROWS * RREP + 1) do_slot($urandom_range(2, 4), got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
